// File: rtl/ledbar_pkg.sv
// Shared types and defaults for the stopwatch LED bar sequencer.
package ledbar_pkg;

    typedef enum logic [1:0] {
        LB_FILL   = 2'd0,
        LB_CHASE  = 2'd1,
        LB_BOUNCE = 2'd2,
        LB_DRAIN  = 2'd3
    } lb_mode_e;

    typedef enum logic {
        LB_UP   = 1'b0,
        LB_DOWN = 1'b1
    } lb_dir_e;

    localparam int unsigned LB_N_LED     = 4;
    localparam int unsigned LB_TICK_DIV  = 200000;
    localparam int unsigned LB_DB_CYCLES = 10000;

endpackage

// File: rtl/ledbar_seq_if.sv
// Control/status bundle between the stopwatch and the LED bar sequencer.
interface ledbar_seq_if #(
    parameter int unsigned N_LED = 4
);
    import ledbar_pkg::*;

    logic             run;
    logic             clr_btn;
    lb_mode_e         mode;
    logic [N_LED-1:0] led;
    logic             step;
    logic             full;

    modport master (output run, clr_btn, mode, input led, step, full);
    modport slave  (input run, clr_btn, mode, output led, step, full);

endinterface

// File: rtl/ledbar_seq_btn_edge.sv
// Push-button synchroniser with rising-edge pulse.
// Optional debounce stage enabled by defining LEDBAR_DEBOUNCE_EN.
module btn_edge #(
    parameter int unsigned DB_CYCLES = 10000
) (
    input  logic mclk,
    input  logic reset,
    input  logic btn,
    output logic rise_c
);
    logic d0;
    logic d1;

`ifdef LEDBAR_DEBOUNCE_EN
    localparam int unsigned DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [DW-1:0] db_cnt;
    logic          db_lvl;
    logic          db_lvl_q;

    // Synchronise, then accept a new level only after it has held DB_CYCLES cycles.
    always_ff @(posedge mclk) begin
        if (reset) begin
            d0       <= 1'b0;
            d1       <= 1'b0;
            db_cnt   <= '0;
            db_lvl   <= 1'b0;
            db_lvl_q <= 1'b0;
        end else begin
            d0       <= btn;
            d1       <= d0;
            db_lvl_q <= db_lvl;
            if (d1 == db_lvl) begin
                db_cnt <= '0;
            end else if (db_cnt == DW'(DB_CYCLES - 1)) begin
                db_lvl <= d1;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    assign rise_c = db_lvl & ~db_lvl_q;
`else
    logic d2;
    logic unused_db;

    // Three-flop chain; the last two stages form the edge detector.
    always_ff @(posedge mclk) begin
        if (reset) begin
            d0 <= 1'b0;
            d1 <= 1'b0;
            d2 <= 1'b0;
        end else begin
            d0 <= btn;
            d1 <= d0;
            d2 <= d1;
        end
    end

    assign rise_c    = d1 & ~d2;
    assign unused_db = ^DB_CYCLES;
`endif

endmodule

// File: rtl/ledbar_seq.sv
// N-LED bar sequencer: FILL/CHASE/BOUNCE/DRAIN patterns stepped by a tick divider.
// Define LEDBAR_DEBOUNCE_EN to debounce the clear button.
module ledbar_seq
    import ledbar_pkg::*;
#(
    parameter int unsigned N_LED     = LB_N_LED,
    parameter int unsigned TICK_DIV  = LB_TICK_DIV,
    parameter int unsigned DB_CYCLES = LB_DB_CYCLES
) (
    input  logic        mclk,
    input  logic        reset,
    ledbar_seq_if.slave bus
);
    localparam int unsigned CW = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
    localparam int unsigned PW = $clog2(N_LED + 1);
    localparam logic [N_LED-1:0] ALL_ONES = '1;

    logic [CW-1:0]    cnt_q, cnt_n;
    logic [PW-1:0]    pos_q, pos_n, adv_pos;
    lb_dir_e          dir_q, dir_n, adv_dir;
    logic [N_LED-1:0] led_q, led_n, adv_led, start_led;
    logic [N_LED:0]   fill_ext;
    logic             step_q, step_n;
    lb_mode_e         mode_q;
    logic             chg_q;
    logic             clr_rise;
    logic             tick;

    btn_edge #(
        .DB_CYCLES(DB_CYCLES)
    ) u_clr (
        .mclk  (mclk),
        .reset (reset),
        .btn   (bus.clr_btn),
        .rise_c(clr_rise)
    );

    // State register; a mode change is flagged one cycle and applied the next.
    always_ff @(posedge mclk) begin
        if (reset) begin
            cnt_q  <= '0;
            pos_q  <= '0;
            dir_q  <= LB_UP;
            led_q  <= '0;
            step_q <= 1'b0;
            mode_q <= LB_FILL;
            chg_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_n;
            pos_q  <= pos_n;
            dir_q  <= dir_n;
            led_q  <= led_n;
            step_q <= step_n;
            mode_q <= bus.mode;
            chg_q  <= (bus.mode != mode_q);
        end
    end

    // Pattern position/LED value one step ahead of the current state.
    always_comb begin
        adv_pos  = pos_q;
        adv_dir  = dir_q;
        adv_led  = led_q;
        fill_ext = '0;
        case (mode_q)
            LB_FILL: begin
                adv_pos  = (pos_q == PW'(N_LED)) ? '0 : pos_q + PW'(1);
                fill_ext = ((N_LED + 1)'(1) << adv_pos) - (N_LED + 1)'(1);
                adv_led  = fill_ext[N_LED-1:0];
            end
            LB_CHASE: begin
                adv_pos = (pos_q == PW'(N_LED - 1)) ? '0 : pos_q + PW'(1);
                adv_led = N_LED'(1) << adv_pos;
            end
            LB_BOUNCE: begin
                if (dir_q == LB_UP) begin
                    if (pos_q == PW'(N_LED - 1)) begin
                        adv_pos = pos_q - PW'(1);
                        adv_dir = LB_DOWN;
                    end else begin
                        adv_pos = pos_q + PW'(1);
                    end
                end else begin
                    if (pos_q == '0) begin
                        adv_pos = PW'(1);
                        adv_dir = LB_UP;
                    end else begin
                        adv_pos = pos_q - PW'(1);
                    end
                end
                adv_led = N_LED'(1) << adv_pos;
            end
            LB_DRAIN: begin
                adv_pos = (pos_q == PW'(N_LED)) ? '0 : pos_q + PW'(1);
                adv_led = ALL_ONES >> adv_pos;
            end
            default: ;
        endcase
    end

    // LED value a pattern starts from after a mode change.
    always_comb begin
        start_led = '0;
        case (mode_q)
            LB_FILL:   start_led = '0;
            LB_CHASE:  start_led = N_LED'(1);
            LB_BOUNCE: start_led = N_LED'(1);
            LB_DRAIN:  start_led = ALL_ONES;
            default:   start_led = '0;
        endcase
    end

    // Next state: mode change > clear (stopped only) > tick advance.
    always_comb begin
        cnt_n  = cnt_q;
        pos_n  = pos_q;
        dir_n  = dir_q;
        led_n  = led_q;
        step_n = 1'b0;
        tick   = bus.run && (cnt_q >= CW'(TICK_DIV));
        if (chg_q) begin
            cnt_n = '0;
            pos_n = '0;
            dir_n = LB_UP;
            led_n = start_led;
        end else if (!bus.run && clr_rise) begin
            cnt_n = '0;
            pos_n = '0;
            dir_n = LB_UP;
            led_n = '0;
        end else if (tick) begin
            cnt_n  = '0;
            pos_n  = adv_pos;
            dir_n  = adv_dir;
            led_n  = adv_led;
            step_n = 1'b1;
        end else if (bus.run) begin
            cnt_n = cnt_q + CW'(1);
        end
    end

    // Outputs straight from the state registers.
    always_comb begin
        bus.led  = led_q;
        bus.step = step_q;
        bus.full = &led_q;
    end

endmodule

// File: tb/tb_ledbar_seq.sv
// Directed self-checking bench for ledbar_seq (N_LED=4, TICK_DIV=4).
module tb_ledbar_seq;
    import ledbar_pkg::*;

    localparam int unsigned N   = 4;
    localparam int unsigned TD  = 4;
    localparam int unsigned DBC = 8;

    logic mclk;
    logic reset;
    int   checks;
    int   failures;

    ledbar_seq_if #(.N_LED(N)) bus ();

    ledbar_seq #(
        .N_LED    (N),
        .TICK_DIV (TD),
        .DB_CYCLES(DBC)
    ) dut (
        .mclk (mclk),
        .reset(reset),
        .bus  (bus)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge mclk);
    endtask

    logic [3:0] fill_exp [5];
    logic       full_exp [5];
    logic [3:0] bnc_exp  [7];

    initial begin
        checks      = 0;
        failures    = 0;
        fill_exp    = '{4'h1, 4'h3, 4'h7, 4'hF, 4'h0};
        full_exp    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        bnc_exp     = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
        reset       = 1'b1;
        bus.run     = 1'b0;
        bus.clr_btn = 1'b0;
        bus.mode    = LB_FILL;
        cyc(2);
        chk("reset_led", 32'(bus.led), 32'h0);
        chk("reset_step", 32'(bus.step), 32'h0);
        chk("reset_full", 32'(bus.full), 32'h0);

        // FILL: one step every TD+1 cycles
        reset   = 1'b0;
        bus.run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(4);
            chk("fill_step_idle", 32'(bus.step), 32'h0);
            cyc(1);
            chk("fill_led", 32'(bus.led), 32'(fill_exp[i]));
            chk("fill_step", 32'(bus.step), 32'h1);
            chk("fill_full", 32'(bus.full), 32'(full_exp[i]));
        end

        // Reset mid-FILL at 0111, then restart from 0001
        cyc(15);
        chk("fill_pre_reset", 32'(bus.led), 32'h7);
        reset = 1'b1;
        cyc(1);
        chk("midreset_led", 32'(bus.led), 32'h0);
        chk("midreset_step", 32'(bus.step), 32'h0);
        chk("midreset_full", 32'(bus.full), 32'h0);
        reset = 1'b0;
        cyc(5);
        chk("restart_led", 32'(bus.led), 32'h1);

        // BOUNCE: start value two cycles after the change, no repeated ends
        bus.mode = LB_BOUNCE;
        cyc(2);
        chk("bounce_start", 32'(bus.led), 32'h1);
        for (int i = 0; i < 7; i++) begin
            cyc(5);
            chk("bounce_led", 32'(bus.led), 32'(bnc_exp[i]));
        end

        // CHASE to 0100, then switch to DRAIN mid-period
        bus.mode = LB_CHASE;
        cyc(2);
        chk("chase_start", 32'(bus.led), 32'h1);
        cyc(10);
        chk("chase_led", 32'(bus.led), 32'h4);
        cyc(2);
        bus.mode = LB_DRAIN;
        cyc(1);
        chk("drain_pending", 32'(bus.led), 32'h4);
        cyc(1);
        chk("drain_start", 32'(bus.led), 32'hF);
        chk("drain_full", 32'(bus.full), 32'h1);
        cyc(4);
        chk("drain_hold", 32'(bus.led), 32'hF);
        chk("drain_step_idle", 32'(bus.step), 32'h0);
        cyc(1);
        chk("drain_first", 32'(bus.led), 32'h7);
        chk("drain_first_step", 32'(bus.step), 32'h1);

        // Clear ignored while running; pattern keeps stepping
        bus.clr_btn = 1'b1;
        cyc(6);
        chk("clr_ignored_run", 32'(bus.led), 32'h3);
        bus.clr_btn = 1'b0;
        bus.run     = 1'b0;
        cyc(4);
        chk("clr_not_queued", 32'(bus.led), 32'h3);

`ifndef LEDBAR_DEBOUNCE_EN
        // Clear while stopped: applied on the third edge after the press
        bus.clr_btn = 1'b1;
        cyc(2);
        chk("clr_latency", 32'(bus.led), 32'h3);
        cyc(1);
        chk("clr_led", 32'(bus.led), 32'h0);
        bus.clr_btn = 1'b0;
        bus.run     = 1'b1;
        cyc(4);
        chk("clr_cnt_zero", 32'(bus.step), 32'h0);
        cyc(1);
        chk("clr_restart_led", 32'(bus.led), 32'h7);
        chk("clr_restart_step", 32'(bus.step), 32'h1);
`else
        // Debounced clear: short glitch rejected, long press accepted
        bus.clr_btn = 1'b1;
        cyc(5);
        bus.clr_btn = 1'b0;
        cyc(12);
        chk("db_glitch", 32'(bus.led), 32'h3);
        bus.clr_btn = 1'b1;
        cyc(10);
        chk("db_press_wait", 32'(bus.led), 32'h3);
        cyc(1);
        chk("db_press_clr", 32'(bus.led), 32'h0);
        bus.clr_btn = 1'b0;
        cyc(2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
